// File: rtl/four_full_adder.sv
`default_nettype none
// ============================================================================
// Module      : four_full_adder
// Description : Registered 16-bit adder built from four cascaded 4-bit
//               ripple-carry stages; exposes the sum and every stage carry.
// Revision    : 1.0 - initial release
// ============================================================================

module fullAdder (
    input  logic x,
    input  logic y,
    input  logic c,
    output logic s,
    output logic co
);
    logic w_half;

    assign w_half = x ^ y;
    assign s      = w_half ^ c;
    assign co     = (x & y) | (c & w_half);
endmodule

module nibbleAdder (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       cI,
    output logic [3:0] s,
    output logic       cO
);
    logic [4:0] w_c;

    assign w_c[0] = cI;

    generate
        for (genvar i = 0; i < 4; i++) begin : g_bit
            fullAdder uFa (
                .x  (x[i]),
                .y  (y[i]),
                .c  (w_c[i]),
                .s  (s[i]),
                .co (w_c[i+1])
            );
        end
    endgenerate

    assign cO = w_c[4];
endmodule

module four_full_adder (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cIn,
    output logic [15:0] sumFinal,
    output logic [3:0]  cOutFinal
);
    localparam int c_STAGES = 4;

    logic [15:0]         w_sum;
    logic [c_STAGES:0]   w_carry;
    logic [15:0]         r_sum;
    logic [c_STAGES-1:0] r_cOut;

    assign w_carry[0] = cIn;

    // Carry chain threads through all four stages within one cycle.
    generate
        for (genvar k = 0; k < c_STAGES; k++) begin : g_stage
            nibbleAdder uStage (
                .x  (a[4*k+3:4*k]),
                .y  (b[4*k+3:4*k]),
                .cI (w_carry[k]),
                .s  (w_sum[4*k+3:4*k]),
                .cO (w_carry[k+1])
            );
        end
    endgenerate

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_sum  <= 16'h0000;
            r_cOut <= 4'b0000;
        end else begin
            r_sum  <= w_sum;
            r_cOut <= w_carry[c_STAGES:1];
        end
    end

    assign sumFinal  = r_sum;
    assign cOutFinal = r_cOut;
endmodule

`default_nettype wire

// File: tb/tb_four_full_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_four_full_adder
// Description : Self-checking bench for four_full_adder.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_four_full_adder;
    logic        Clk;
    logic        Rst;
    logic [15:0] a;
    logic [15:0] b;
    logic        cIn;
    logic [15:0] sumFinal;
    logic [3:0]  cOutFinal;

    int errors = 0;
    int checks = 0;

    four_full_adder dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .a         (a),
        .b         (b),
        .cIn       (cIn),
        .sumFinal  (sumFinal),
        .cOutFinal (cOutFinal)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Inputs change on the falling edge; outputs are read on the falling edge.
    task automatic drive(input logic [15:0] va, input logic [15:0] vb, input logic vc);
        a   = va;
        b   = vb;
        cIn = vc;
        @(negedge Clk);
    endtask

    function automatic logic [3:0] refCarry(input logic [15:0] va, input logic [15:0] vb, input logic vc);
        logic [3:0] r;
        for (int k = 0; k < 4; k++) begin
            logic [31:0] mask;
            logic [31:0] tot;
            mask = (32'd1 << (4*k+4)) - 32'd1;
            tot  = ({16'd0, va} & mask) + ({16'd0, vb} & mask) + {31'd0, vc};
            r[k] = tot[4*k+4];
        end
        return r;
    endfunction

    task automatic test_reset;
        Rst = 1'b1;
        a = 16'h1234; b = 16'h1111; cIn = 1'b0;
        #1;
        checks++;
        if (sumFinal !== 16'h0000 || cOutFinal !== 4'b0000) begin
            errors++;
            $display("FAIL reset_immediate: sum=%h cout=%b required sum=0000 cout=0000", sumFinal, cOutFinal);
        end
        @(negedge Clk); @(negedge Clk);
        checks++;
        if (sumFinal !== 16'h0000 || cOutFinal !== 4'b0000) begin
            errors++;
            $display("FAIL reset_held: sum=%h cout=%b required sum=0000 cout=0000", sumFinal, cOutFinal);
        end
        Rst = 1'b0;
        @(negedge Clk);
        checks++;
        if (sumFinal !== 16'h2345 || cOutFinal !== 4'b0000) begin
            errors++;
            $display("FAIL reset_release: sum=%h cout=%b required sum=2345 cout=0000", sumFinal, cOutFinal);
        end
    endtask

    task automatic test_sweep;
        logic [15:0] expSum;
        for (int i = 0; i <= 16; i++) begin
            if (i > 0) begin
                expSum = 16'(1 + 256 * (i - 1));
                checks++;
                if (sumFinal !== expSum || cOutFinal !== 4'b0000) begin
                    errors++;
                    $display("FAIL sweep_%0d: sum=%h cout=%b required sum=%h cout=0000", i-1, sumFinal, cOutFinal, expSum);
                end
            end
            a = 16'h0001; cIn = 1'b0; b = 16'(i << 8);
            @(negedge Clk);
        end
    endtask

    task automatic test_directed;
        logic [15:0] va [6] = '{16'hFFFF, 16'hFFFF, 16'hAAAA, 16'h0F0F, 16'hCBA9, 16'h0000};
        logic [15:0] vb [6] = '{16'hFFFF, 16'hFFFF, 16'h5555, 16'hF0F0, 16'h8765, 16'h0000};
        logic        vc [6] = '{1'b0,     1'b1,     1'b1,     1'b0,     1'b0,     1'b1};
        logic [15:0] es [6] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h530E, 16'h0001};
        logic [3:0]  ec [6] = '{4'b1111,  4'b1111,  4'b1111,  4'b0000,  4'b1110,  4'b0000};
        for (int i = 0; i < 6; i++) begin
            drive(va[i], vb[i], vc[i]);
            checks++;
            if (sumFinal !== es[i] || cOutFinal !== ec[i]) begin
                errors++;
                $display("FAIL directed_%0d: a=%h b=%h cin=%b sum=%h cout=%b required sum=%h cout=%b",
                         i, va[i], vb[i], vc[i], sumFinal, cOutFinal, es[i], ec[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        drive(16'h7777, 16'h1111, 1'b0);
        #2 Rst = 1'b1;
        #1;
        checks++;
        if (sumFinal !== 16'h0000 || cOutFinal !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid: sum=%h cout=%b required sum=0000 cout=0000", sumFinal, cOutFinal);
        end
        a = 16'hFFFF; b = 16'h0001; cIn = 1'b1;
        @(negedge Clk);
        checks++;
        if (sumFinal !== 16'h0000 || cOutFinal !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid_held: sum=%h cout=%b required sum=0000 cout=0000", sumFinal, cOutFinal);
        end
        Rst = 1'b0;
        @(negedge Clk);
        checks++;
        if (sumFinal !== 16'h0001 || cOutFinal !== 4'b1111) begin
            errors++;
            $display("FAIL reset_mid_release: sum=%h cout=%b required sum=0001 cout=1111", sumFinal, cOutFinal);
        end
    endtask

    task automatic test_random;
        logic [15:0] ra, rb;
        logic        rc;
        logic [16:0] full;
        logic [15:0] expSum;
        logic [3:0]  expC;
        for (int i = 0; i <= 1000; i++) begin
            if (i > 0) begin
                checks++;
                if (sumFinal !== expSum || cOutFinal !== expC) begin
                    errors++;
                    $display("FAIL random_%0d: a=%h b=%h cin=%b sum=%h cout=%b required sum=%h cout=%b",
                             i-1, ra, rb, rc, sumFinal, cOutFinal, expSum, expC);
                end
            end
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom_range(0, 1));
            full   = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
            expSum = full[15:0];
            expC   = refCarry(ra, rb, rc);
            a = ra; b = rb; cIn = rc;
            @(negedge Clk);
        end
    endtask

    initial begin
        test_reset;
        test_sweep;
        test_directed;
        test_reset_mid;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire
